unified_mem_arbiter: RTL and testbench

//  Shares one single-ported synchronous memory between the pipeline's IF port (PC_out/inst_in)
//  and its MEM port (ALU_out/data_out/mem_w/data_in), for a unified code+data memory.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_starve_ctr.sv | 36 +++
 rtl/unified_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_unified_mem_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified code+data memory arbiter.
//  - state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE)
//  - gnt_t   : which requester owns the access in flight
//  - counter widths for the latency and starvation counters (both 0..15)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

  localparam int LAT_CNT_W    = 4;
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating starvation counter for the instruction-fetch port.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  d_grant_starving  a data grant was made while a fetch was also waiting
//  if_grant          a fetch grant was made (clears the count)
//  force_if          count has reached STARVE_LIMIT: fetch must win the next tie
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic d_grant_starving,
  input  logic if_grant,
  output logic force_if
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] starve_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (if_grant) begin
      starve_cnt_reg <= '0;
    end else if (d_grant_starving && (starve_cnt_reg != LIMIT)) begin
      // Saturate at the limit; once there, the fetch wins every tie anyway.
      starve_cnt_reg <= starve_cnt_reg + STARVE_CNT_W'(1);
    end
  end

  assign force_if = (starve_cnt_reg == LIMIT);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported synchronous memory between the fetch (IF) port
// and the data (MEM) port of a pipeline with unified code+data memory.
// Ports:
//  clk, rst                          clock, synchronous active-high reset
//  if_req/if_addr -> if_rdata/if_ready   fetch request and response
//  d_req/d_we/d_addr/d_wdata -> d_rdata/d_ready   data request and response
//  mem_en/mem_we/mem_addr/mem_wdata, mem_rdata    memory side
//  busy                              high in every state except IDLE
// One access at a time: IDLE grants, ACCESS waits MEM_LAT cycles after the
// strobe and captures read data, RESP emits a one-cycle ready pulse.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t                 state_reg, state_next;
  gnt_t                   gnt_reg;
  logic                   we_reg;
  logic [LAT_CNT_W-1:0]   lat_cnt_reg;
  logic                   mem_en_reg, mem_we_reg;
  logic [ADDR_W-1:0]      mem_addr_reg;
  logic [DATA_W-1:0]      mem_wdata_reg;
  logic [DATA_W-1:0]      if_rdata_reg, d_rdata_reg;

  logic force_if;
  logic take_grant;
  logic grant_is_if;
  logic lat_done;

  // Data wins a tie unless the fetch port has been starved long enough.
  assign grant_is_if = if_req && (!d_req || force_if);
  assign take_grant  = (state_reg == IDLE) && (if_req || d_req);
  // Counter starts at 0 on the strobe cycle, so MEM_LAT is reached exactly
  // when the memory presents the read data.
  assign lat_done    = (lat_cnt_reg == LAT_CNT_W'(MEM_LAT));

  arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk              (clk),
    .rst              (rst),
    .d_grant_starving (take_grant && !grant_is_if && if_req),
    .if_grant         (take_grant && grant_is_if),
    .force_if         (force_if)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (if_req || d_req) state_next = ACCESS;
      ACCESS:  if (lat_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      gnt_reg       <= GNT_IF;
      we_reg        <= 1'b0;
      lat_cnt_reg   <= '0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      d_rdata_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      // Strobe is the registered grant: high only in the first ACCESS cycle.
      mem_en_reg <= take_grant;
      mem_we_reg <= take_grant && !grant_is_if && d_we;
      if (take_grant) begin
        gnt_reg      <= grant_is_if ? GNT_IF : GNT_D;
        we_reg       <= !grant_is_if && d_we;
        mem_addr_reg <= grant_is_if ? if_addr : d_addr;
        if (!grant_is_if) mem_wdata_reg <= d_wdata;
        lat_cnt_reg  <= '0;
      end
      if (state_reg == ACCESS) begin
        if (!lat_done) begin
          lat_cnt_reg <= lat_cnt_reg + LAT_CNT_W'(1);
        end else if (gnt_reg == GNT_IF) begin
          if_rdata_reg <= mem_rdata;
        end else if (!we_reg) begin
          d_rdata_reg <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign if_rdata  = if_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign if_ready  = (state_reg == RESP) && (gnt_reg == GNT_IF);
  assign d_ready   = (state_reg == RESP) && (gnt_reg == GNT_D);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance with MEM_LAT=1 and a
// second with MEM_LAT=3. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge. Cycle 0 is the cycle in which a
// request is first presented while the arbiter is idle.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // MEM_LAT = 1 instance
  logic        if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_en, mem_we, busy;

  // MEM_LAT = 3 instance
  logic        if_req3 = 0, d_req3 = 0, d_we3 = 0;
  logic [31:0] if_addr3 = 0, d_addr3 = 0, d_wdata3 = 0;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3, mem_rdata3;
  logic        if_ready3, d_ready3, mem_en3, mem_we3, busy3;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_LIMIT(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_rdata(if_rdata3), .if_ready(if_ready3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_rdata(d_rdata3), .d_ready(d_ready3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata3), .busy(busy3)
  );

  // Memory model, latency 1. Read data is only valid in the cycle after the
  // strobe; other cycles carry a junk pattern so mistimed captures show up.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) mem[64] <= 32'h00500093;            // word at 0x100
    if (mem_en && mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hBADBAD00;
  end

  // Memory model, latency 3: data = addr ^ 0x5A5A0000, valid for one cycle.
  logic [31:0] p1, p2;
  always @(posedge clk) begin
    p1         <= mem_en3 ? (mem_addr3 ^ 32'h5A5A0000) : 32'hBADBAD03;
    p2         <= p1;
    mem_rdata3 <= p2;
  end

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({if_ready, d_ready, mem_en, mem_we} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {if_ready, d_ready, mem_en, mem_we}); end
    checks++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, d_rdata}); end
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy3: got %b expected 0", busy3); end
    @(posedge clk); #1 rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_lone_fetch;
    int en_cyc = -1, rdy_cyc = -1, en_cnt = 0, d_pulses = 0;
    logic [31:0] en_addr = 0; logic en_we = 1'b1; logic drop = 0;
    @(posedge clk); #1; if_addr = 32'h100; if_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_en) begin en_cnt++; if (en_cyc < 0) begin en_cyc = c; en_addr = mem_addr; en_we = mem_we; end end
      if (if_ready && rdy_cyc < 0) begin rdy_cyc = c; drop = 1; end
      if (d_ready) d_pulses++;
      @(posedge clk); #1;
      if (drop) if_req = 1'b0;
    end
    checks++; if (en_cyc !== 1) begin errors++; $display("FAIL fetch_en_cycle: got %0d expected 1", en_cyc); end
    checks++; if (en_addr !== 32'h100) begin errors++; $display("FAIL fetch_mem_addr: got %h expected 00000100", en_addr); end
    checks++; if (en_we !== 1'b0) begin errors++; $display("FAIL fetch_mem_we: got %b expected 0", en_we); end
    checks++; if (rdy_cyc !== 3) begin errors++; $display("FAIL fetch_ready_cycle: got %0d expected 3", rdy_cyc); end
    checks++; if (if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_rdata: got %h expected 00500093", if_rdata); end
    checks++; if (en_cnt !== 1 || d_pulses !== 0) begin errors++; $display("FAIL fetch_single: got en=%0d d_ready=%0d expected 1 and 0", en_cnt, d_pulses); end
    $display("lone_fetch: addr=100 ready_cycle=%0d rdata=%h", rdy_cyc, if_rdata);
  endtask

  task automatic test_store_load;
    for (int pass = 0; pass < 2; pass++) begin
      int en_cyc = -1, rdy_cyc = -1, we_bad = 0;
      logic en_we = 1'b0; logic [31:0] en_wdata = 0, en_addr = 0; logic drop = 0;
      @(posedge clk); #1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF; d_we = (pass == 0); d_req = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (mem_we && !mem_en) we_bad++;
        if (mem_en && en_cyc < 0) begin en_cyc = c; en_we = mem_we; en_wdata = mem_wdata; en_addr = mem_addr; end
        if (d_ready && rdy_cyc < 0) begin rdy_cyc = c; drop = 1; end
        @(posedge clk); #1;
        if (drop) begin d_req = 1'b0; d_we = 1'b0; end
      end
      checks++; if (rdy_cyc !== 3 || en_cyc !== 1 || en_addr !== 32'h40) begin errors++; $display("FAIL sl%0d_timing: got en=%0d ready=%0d addr=%h expected 1 3 00000040", pass, en_cyc, rdy_cyc, en_addr); end
      checks++; if (we_bad !== 0) begin errors++; $display("FAIL sl%0d_we_without_en: got %0d expected 0", pass, we_bad); end
      if (pass == 0) begin
        checks++; if (en_we !== 1'b1 || en_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_strobe: got we=%b wdata=%h expected 1 deadbeef", en_we, en_wdata); end
        checks++; if (d_rdata !== 32'h0) begin errors++; $display("FAIL store_rdata_kept: got %h expected 00000000", d_rdata); end
        $display("store: addr=40 wdata=deadbeef ready_cycle=%0d", rdy_cyc);
      end else begin
        checks++; if (en_we !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata: got we=%b rdata=%h expected 0 deadbeef", en_we, d_rdata); end
        $display("load: addr=40 ready_cycle=%0d rdata=%h", rdy_cyc, d_rdata);
      end
    end
  endtask

  task automatic test_simultaneous;
    int d_cyc = -1, i_cyc = -1, both = 0, n_en = 0;
    logic [31:0] first_addr = 0, second_addr = 0;
    logic drop_d = 0, drop_i = 0;
    @(posedge clk); #1;
    if_addr = 32'h100; if_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (mem_en) begin n_en++; if (n_en == 1) first_addr = mem_addr; else if (n_en == 2) second_addr = mem_addr; end
      if (if_ready && d_ready) both++;
      if (d_ready && d_cyc < 0) begin d_cyc = c; drop_d = 1; end
      if (if_ready && i_cyc < 0) begin i_cyc = c; drop_i = 1; end
      @(posedge clk); #1;
      if (drop_d) d_req = 1'b0;
      if (drop_i) if_req = 1'b0;
    end
    checks++; if (first_addr !== 32'h40 || second_addr !== 32'h100) begin errors++; $display("FAIL tie_order: got %h then %h expected 00000040 then 00000100", first_addr, second_addr); end
    checks++; if (d_cyc !== 3 || i_cyc !== 7) begin errors++; $display("FAIL tie_ready_cycles: got d=%0d if=%0d expected 3 and 7", d_cyc, i_cyc); end
    checks++; if (both !== 0) begin errors++; $display("FAIL tie_ready_overlap: got %0d expected 0", both); end
    checks++; if (d_rdata !== 32'hDEADBEEF || if_rdata !== 32'h00500093) begin errors++; $display("FAIL tie_data: got d=%h if=%h expected deadbeef 00500093", d_rdata, if_rdata); end
    $display("simultaneous: d_ready=%0d if_ready=%0d", d_cyc, i_cyc);
  endtask

  task automatic test_starvation;
    logic [5:0] order = '0;
    int n = 0, both = 0;
    logic [3:0] cnt_at4 = 4'hF, cnt_at5 = 4'hF;
    logic drop = 0;
    @(posedge clk); #1;
    if_addr = 32'h100; if_req = 1'b1; d_addr = 32'h40; d_we = 1'b0; d_req = 1'b1;
    for (int c = 0; c < 40 && !drop; c++) begin
      @(negedge clk);
      if (if_ready && d_ready) both++;
      if ((if_ready || d_ready) && n < 6) begin
        order[n] = if_ready;
        n++;
        if (n == 4) cnt_at4 = dut.u_starve.starve_cnt_reg;
        if (n == 5) cnt_at5 = dut.u_starve.starve_cnt_reg;
        if (n == 6) drop = 1;
      end
      @(posedge clk); #1;
      if (drop) begin if_req = 1'b0; d_req = 1'b0; end
    end
    if_req = 1'b0; d_req = 1'b0;
    checks++; if (n !== 6 || order !== 6'b010000) begin errors++; $display("FAIL starve_order: got n=%0d order(bit0 first, 1=IF)=%b expected 6 010000", n, order); end
    checks++; if (cnt_at4 !== 4'd4) begin errors++; $display("FAIL starve_cnt_limit: got %0d expected 4", cnt_at4); end
    checks++; if (cnt_at5 !== 4'd0) begin errors++; $display("FAIL starve_cnt_clear: got %0d expected 0", cnt_at5); end
    checks++; if (both !== 0) begin errors++; $display("FAIL starve_ready_overlap: got %0d expected 0", both); end
    $display("starvation: %0d grants order=%b", n, order);
  endtask

  task automatic test_lat3;
    int en_cyc = -1, rdy_cyc = -1, b_first = -1, b_last = -1, b_cnt = 0;
    logic drop = 0;
    @(posedge clk); #1; d_addr3 = 32'h200; d_we3 = 1'b0; d_req3 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (mem_en3 && en_cyc < 0) en_cyc = c;
      if (busy3) begin b_cnt++; b_last = c; if (b_first < 0) b_first = c; end
      if (d_ready3 && rdy_cyc < 0) begin rdy_cyc = c; drop = 1; end
      @(posedge clk); #1;
      if (drop) d_req3 = 1'b0;
    end
    checks++; if (en_cyc !== 1 || rdy_cyc !== 5) begin errors++; $display("FAIL lat3_cycles: got en=%0d ready=%0d expected 1 5", en_cyc, rdy_cyc); end
    checks++; if (b_first !== 1 || b_last !== 5 || b_cnt !== 5) begin errors++; $display("FAIL lat3_busy: got %0d..%0d count %0d expected 1..5 count 5", b_first, b_last, b_cnt); end
    checks++; if (d_rdata3 !== 32'h5A5A0200) begin errors++; $display("FAIL lat3_rdata: got %h expected 5a5a0200", d_rdata3); end
    $display("lat3_load: addr=200 ready_cycle=%0d rdata=%h", rdy_cyc, d_rdata3);
  endtask

  task automatic test_reset_mid;
    int pulses = 0, rdy_cyc = -1;
    logic drop = 0;
    @(posedge clk); #1; if_addr = 32'h100; if_req = 1'b1;
    @(posedge clk); #1;                      // cycle 1: ACCESS
    rst = 1'b1; if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);                          // cycle 2: after reset edge
    checks++; if (busy !== 1'b0 || {if_ready, d_ready, mem_en, mem_we} !== 4'b0) begin errors++; $display("FAIL midrst_state: got busy=%b strobes=%b expected 0 0000", busy, {if_ready, d_ready, mem_en, mem_we}); end
    checks++; if ({mem_addr, if_rdata, d_rdata} !== 96'h0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", {mem_addr, if_rdata, d_rdata}); end
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); if (if_ready || d_ready || busy) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_ready: got %0d active cycles expected 0", pulses); end
    @(posedge clk); #1; if_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (if_ready && rdy_cyc < 0) begin rdy_cyc = c; drop = 1; end
      @(posedge clk); #1;
      if (drop) if_req = 1'b0;
    end
    checks++; if (rdy_cyc !== 3 || if_rdata !== 32'h00500093) begin errors++; $display("FAIL midrst_refetch: got ready=%0d rdata=%h expected 3 00500093", rdy_cyc, if_rdata); end
    $display("reset_mid_access: refetch ready_cycle=%0d rdata=%h", rdy_cyc, if_rdata);
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_store_load();
    test_simultaneous();
    test_starvation();
    test_lat3();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
